reg_scoreboard: RTL and testbench

Dual-issue register scoreboard for the 2-wide RV32 core. It tracks which architectural registers have a write in flight and decides each cycle whether issue slot 0 and slot 1 may read the shared register file. It sits between decode and the issue/execute pipes and is driven by the two writeback ports. The register file forwards same-cycle writeback data, so a writeback releases its register in the same cycle.

---
 rtl/reg_scoreboard.sv | 102 ++++++++++
 tb/tb_reg_scoreboard.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - dual-issue register scoreboard with same-cycle writeback release
module reg_scoreboard #(
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            flush,
    input  logic            issue_v0,
    input  logic            issue_v1,
    input  logic [4:0]      rs1_0,
    input  logic [4:0]      rs2_0,
    input  logic [4:0]      rd_0,
    input  logic [4:0]      rs1_1,
    input  logic [4:0]      rs2_1,
    input  logic [4:0]      rd_1,
    input  logic            rd_we_0,
    input  logic            rd_we_1,
    input  logic            wb_v0,
    input  logic            wb_v1,
    input  logic [4:0]      wb_rd0,
    input  logic [4:0]      wb_rd1,
    output logic            stall_0,
    output logic            stall_1,
    output logic            fire_0,
    output logic            fire_1,
    output logic [NREG-1:0] busy_vec,
    output logic [5:0]      pending_cnt,
    output logic            sb_err
);

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    logic [NREG-1:0] rel;
    logic [NREG-1:0] eb;
    logic [NREG-1:0] set0;
    logic [NREG-1:0] set1;
    logic [NREG-1:0] busy_nxt;
    logic [5:0]      cnt_nxt;
    logic            hazard0;
    logic            hazard1;
    logic            pair;
    logic            err_hit;

    function automatic logic hz(input logic [4:0] rs, input logic [NREG-1:0] e);
        return (rs != 5'd0) && e[rs];
    endfunction

    always_comb begin
        rel = '0;
        for (int r = 1; r < NREG; r++) begin
            rel[r] = (wb_v0 && wb_rd0 == 5'(r)) || (wb_v1 && wb_rd1 == 5'(r));
        end
    end

    assign eb = busy_vec & ~rel;

    assign hazard0 = hz(rs1_0, eb) | hz(rs2_0, eb) | (rd_we_0 & hz(rd_0, eb));
    assign hazard1 = hz(rs1_1, eb) | hz(rs2_1, eb) | (rd_we_1 & hz(rd_1, eb));

    // Slot 1 may not consume or overwrite what slot 0 produces in the same cycle
    assign pair = issue_v0 & rd_we_0 & (rd_0 != 5'd0) &
                  ((rd_0 == rs1_1) | (rd_0 == rs2_1) | (rd_we_1 & (rd_0 == rd_1)));

    assign stall_0 = issue_v0 & (hazard0 | hold | flush);
    assign stall_1 = issue_v1 & (stall_0 | hold | flush | pair | hazard1);
    assign fire_0  = issue_v0 & ~stall_0;
    assign fire_1  = issue_v1 & ~stall_1;

    assign set0 = (fire_0 && rd_we_0 && rd_0 != 5'd0) ? (ONE << rd_0) : '0;
    assign set1 = (fire_1 && rd_we_1 && rd_1 != 5'd0) ? (ONE << rd_1) : '0;

    assign busy_nxt = flush ? '0 : (eb | set0 | set1);

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + 6'(busy_nxt[i]);
        end
    end

    // Writeback to an idle register, or both ports retiring the same register
    assign err_hit = ~flush & (
                     (wb_v0 && wb_rd0 != 5'd0 && !busy_vec[wb_rd0]) ||
                     (wb_v1 && wb_rd1 != 5'd0 && !busy_vec[wb_rd1]) ||
                     (wb_v0 && wb_v1 && wb_rd0 == wb_rd1 && wb_rd0 != 5'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_vec    <= '0;
            pending_cnt <= '0;
            sb_err      <= 1'b0;
        end else begin
            busy_vec    <= busy_nxt;
            pending_cnt <= cnt_nxt;
            if (err_hit) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - vector table plus scoreboard queue for reg_scoreboard
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hold, flush, issue_v0, issue_v1, rd_we_0, rd_we_1, wb_v0, wb_v1;
    logic [4:0]  rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1, wb_rd0, wb_rd1;
    logic        stall_0, stall_1, fire_0, fire_1, sb_err;
    logic [31:0] busy_vec;
    logic [5:0]  pending_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.NREG(32)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .issue_v0(issue_v0), .issue_v1(issue_v1),
        .rs1_0(rs1_0), .rs2_0(rs2_0), .rd_0(rd_0),
        .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1),
        .rd_we_0(rd_we_0), .rd_we_1(rd_we_1),
        .wb_v0(wb_v0), .wb_v1(wb_v1), .wb_rd0(wb_rd0), .wb_rd1(wb_rd1),
        .stall_0(stall_0), .stall_1(stall_1), .fire_0(fire_0), .fire_1(fire_1),
        .busy_vec(busy_vec), .pending_cnt(pending_cnt), .sb_err(sb_err)
    );

    typedef struct {
        logic        iv0;
        logic [4:0]  a0, b0, d0;
        logic        we0;
        logic        iv1;
        logic [4:0]  a1, b1, d1;
        logic        we1;
        logic        wv0;
        logic [4:0]  wr0;
        logic        wv1;
        logic [4:0]  wr1;
        logic        hld, fls;
        logic        s0, s1, f0, f1;
        logic [31:0] busy;
        logic [5:0]  cnt;
        logic        err;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] busy;
        logic [5:0]  cnt;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv0, input logic [4:0] a0, b0, d0, input logic we0,
                       input logic iv1, input logic [4:0] a1, b1, d1, input logic we1,
                       input logic wv0, input logic [4:0] wr0, input logic wv1, input logic [4:0] wr1,
                       input logic hld, fls, input logic s0, s1, f0, f1,
                       input logic [31:0] busy, input logic [5:0] cnt, input logic err);
        vec_t v;
        v.iv0 = iv0; v.a0 = a0; v.b0 = b0; v.d0 = d0; v.we0 = we0;
        v.iv1 = iv1; v.a1 = a1; v.b1 = b1; v.d1 = d1; v.we1 = we1;
        v.wv0 = wv0; v.wr0 = wr0; v.wv1 = wv1; v.wr1 = wr1;
        v.hld = hld; v.fls = fls;
        v.s0 = s0; v.s1 = s1; v.f0 = f0; v.f1 = f1;
        v.busy = busy; v.cnt = cnt; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        hold = 0; flush = 0; issue_v0 = 0; issue_v1 = 0; rd_we_0 = 0; rd_we_1 = 0;
        wb_v0 = 0; wb_v1 = 0; rs1_0 = 0; rs2_0 = 0; rd_0 = 0; rs1_1 = 0; rs2_1 = 0;
        rd_1 = 0; wb_rd0 = 0; wb_rd1 = 0;
    endtask

    task automatic drive(input vec_t v);
        issue_v0 = v.iv0; rs1_0 = v.a0; rs2_0 = v.b0; rd_0 = v.d0; rd_we_0 = v.we0;
        issue_v1 = v.iv1; rs1_1 = v.a1; rs2_1 = v.b1; rd_1 = v.d1; rd_we_1 = v.we1;
        wb_v0 = v.wv0; wb_rd0 = v.wr0; wb_v1 = v.wv1; wb_rd1 = v.wr1;
        hold = v.hld; flush = v.fls;
    endtask

    // Called at posedge+1: check outputs, step one clock, return at posedge+1
    task automatic step_check_state(input string tag, input logic [31:0] busy,
                                    input logic [5:0] cnt, input logic err);
        @(posedge clk); #1;
        chk({tag, " busy_vec"}, busy_vec, busy);
        chk({tag, " pending_cnt"}, 32'(pending_cnt), 32'(cnt));
        chk({tag, " sb_err"}, 32'(sb_err), 32'(err));
    endtask

    initial begin
        exp_t e;
        logic [31:0] fill;
        idle_inputs();
        #12;
        chk("reset busy_vec", busy_vec, 32'h0);
        chk("reset pending_cnt", 32'(pending_cnt), 32'h0);
        chk("reset sb_err", 32'(sb_err), 32'h0);
        chk("reset stall/fire", {28'h0, stall_0, stall_1, fire_0, fire_1}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        //  iv0 a0 b0 d0 we0  iv1 a1 b1 d1 we1  wv0 wr0 wv1 wr1 hld fls  s0 s1 f0 f1  busy cnt err
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  32'h0,   0, 0);
        add(1, 0, 0, 5, 1,  0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0, 1, 0,  32'h20,  1, 0);
        add(1, 0, 0, 6, 1,  1, 6, 0, 8, 1,  0, 0,  0, 0,  0, 0,  0, 1, 1, 0,  32'h60,  2, 0);
        add(0, 0, 0, 0, 0,  1, 6, 0, 8, 1,  0, 0,  0, 0,  0, 0,  0, 1, 0, 0,  32'h60,  2, 0);
        add(0, 0, 0, 0, 0,  1, 6, 0, 8, 1,  1, 6,  0, 0,  0, 0,  0, 0, 0, 1,  32'h120, 2, 0);
        add(1, 0, 0, 7, 1,  0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0, 1, 0,  32'h1A0, 3, 0);
        add(1, 0, 0, 7, 1,  1, 1, 0, 2, 1,  0, 0,  0, 0,  0, 0,  1, 1, 0, 0,  32'h1A0, 3, 0);
        add(1, 0, 0, 0, 1,  1, 0, 0, 0, 1,  0, 0,  0, 0,  0, 0,  0, 0, 1, 1,  32'h1A0, 3, 0);
        add(1, 0, 0, 9, 1,  0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0, 1, 0,  32'h3A0, 4, 0);
        add(1, 0, 0, 9, 1,  0, 0, 0, 0, 0,  0, 0,  1, 9,  0, 0,  0, 0, 1, 0,  32'h3A0, 4, 0);
        add(1, 0, 0, 10, 1, 1, 0, 0, 11, 1, 0, 0,  0, 0,  1, 0,  1, 1, 0, 0,  32'h3A0, 4, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 5,  1, 7,  0, 0,  0, 0, 0, 0,  32'h300, 2, 0);
        add(1, 0, 0, 3, 1,  1, 0, 0, 4, 1,  0, 0,  0, 0,  0, 0,  0, 0, 1, 1,  32'h318, 4, 0);
        add(1, 0, 0, 6, 1,  0, 0, 0, 0, 0,  1, 8,  1, 9,  0, 0,  0, 0, 1, 0,  32'h58,  3, 0);
        add(1, 0, 0, 10, 1, 1, 0, 0, 11, 1, 1, 12, 0, 0,  0, 1,  1, 1, 0, 0,  32'h0,   0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0,  0, 0,  0, 0,  0, 0, 0, 0,  32'h0,   0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 12, 0, 0,  0, 0,  0, 0, 0, 0,  32'h0,   0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d stall_0", i), 32'(stall_0), 32'(vecs[i].s0));
            chk($sformatf("vec%0d stall_1", i), 32'(stall_1), 32'(vecs[i].s1));
            chk($sformatf("vec%0d fire_0", i), 32'(fire_0), 32'(vecs[i].f0));
            chk($sformatf("vec%0d fire_1", i), 32'(fire_1), 32'(vecs[i].f1));
            e.idx = i; e.busy = vecs[i].busy; e.cnt = vecs[i].cnt; e.err = vecs[i].err;
            sb_q.push_back(e);
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin
                chk("scoreboard underflow", 32'(sb_q.size()), 32'h1);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("vec%0d busy_vec", e.idx), busy_vec, e.busy);
                chk($sformatf("vec%0d pending_cnt", e.idx), 32'(pending_cnt), 32'(e.cnt));
                chk($sformatf("vec%0d sb_err", e.idx), 32'(sb_err), 32'(e.err));
            end
        end
        chk("scoreboard drained", 32'(sb_q.size()), 32'h0);

        // sb_err is sticky across idle cycles
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            step_check_state($sformatf("idle%0d", c), 32'h0, 6'd0, 1'b1);
        end

        // Mid-cycle asynchronous reset clears state without a clock edge
        issue_v0 = 1; rd_0 = 14; rd_we_0 = 1;
        step_check_state("pre_areset", 32'h4000, 6'd1, 1'b1);
        idle_inputs();
        #1 reset = 1'b0;
        #1;
        chk("areset busy_vec", busy_vec, 32'h0);
        chk("areset pending_cnt", 32'(pending_cnt), 32'h0);
        chk("areset sb_err", 32'(sb_err), 32'h0);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Both writeback ports retiring the same busy register is an error
        issue_v0 = 1; rd_0 = 13; rd_we_0 = 1;
        step_check_state("dup_set", 32'h2000, 6'd1, 1'b0);
        idle_inputs();
        wb_v0 = 1; wb_rd0 = 13; wb_v1 = 1; wb_rd1 = 13;
        step_check_state("dup_wb", 32'h0, 6'd0, 1'b1);
        idle_inputs();
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Fill every writable register; count tops out at 31
        fill = 32'h0;
        for (int r = 1; r < 32; r++) begin
            issue_v0 = 1; rd_0 = 5'(r); rd_we_0 = 1;
            #1;
            chk($sformatf("fill%0d fire_0", r), 32'(fire_0), 32'h1);
            fill[r] = 1'b1;
            step_check_state($sformatf("fill%0d", r), fill, 6'(r), 1'b0);
        end
        issue_v0 = 1; rd_0 = 5'd31; rd_we_0 = 1;
        #1;
        chk("full waw stall_0", 32'(stall_0), 32'h1);
        step_check_state("full hold", 32'hFFFF_FFFE, 6'd31, 1'b0);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
